// File: rtl/mdr_unit.sv
// Iterative signed multiply / divide / integer square root unit.
// One shared add/sub datapath, radix-2 per cycle, start/busy/done handshake.
module mdr_unit #(
  parameter int unsigned WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [WORD_LENGTH-1:0]     data_a,
  input  logic [WORD_LENGTH-1:0]     data_b,
  output logic                       busy,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   result,
  output logic                       error
);

  localparam int unsigned W  = WORD_LENGTH;
  localparam int unsigned H  = W / 2;
  localparam int unsigned AW = W + 2;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] OpMul  = 2'b00;
  localparam logic [1:0] OpDiv  = 2'b01;
  localparam logic [1:0] OpSqrt = 2'b10;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [W-1:0]    opnd_q, opnd_d;      // |A| for multiply, |B| for divide
  logic [2*W-1:0]  acc_q, acc_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [H-1:0]    root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [2*W-1:0]  result_q, result_d;

  logic [W-1:0]    mag_a, mag_b;
  logic            pre_err;
  logic [W:0]      div_sh;
  logic [AW-1:0]   sqrt_sh;
  logic [AW-1:0]   alu_a, alu_b, alu_y;
  logic            alu_sub;
  logic [H:0]      sq_rem;
  logic [W-1:0]    quo_s, rem_s;

  assign mag_a   = data_a[W-1] ? (~data_a + 1'b1) : data_a;
  assign mag_b   = data_b[W-1] ? (~data_b + 1'b1) : data_b;
  assign pre_err = (op == 2'b11) ||
                   (op == OpDiv && data_b == '0) ||
                   (op == OpSqrt && data_a[W-1]) ||
                   (op == OpDiv && data_a == MinVal && data_b == '1);

  assign div_sh  = {rem_q[W-1:0], acc_q[W-1]};
  assign sqrt_sh = {rem_q[AW-3:0], acc_q[W-1:W-2]};

  // Operand selection for the single shared adder.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    if (state_q == StCalc) begin
      unique case (op_q)
        OpMul: begin
          alu_a = AW'(acc_q[2*W-1:W]);
          alu_b = acc_q[0] ? AW'(opnd_q) : '0;
        end
        OpDiv: begin
          alu_a   = AW'(div_sh);
          alu_b   = AW'(opnd_q);
          alu_sub = 1'b1;
        end
        OpSqrt: begin
          // Non-restoring: subtract {Q,01} after a non-negative step, add {Q,11} otherwise.
          alu_a   = sqrt_sh;
          alu_b   = AW'({root_q, rem_q[AW-1], 1'b1});
          alu_sub = ~rem_q[AW-1];
        end
        default: ;
      endcase
    end else if (state_q == StFin) begin
      // Final sqrt remainder correction: R += 2Q+1 when negative.
      alu_a = rem_q;
      alu_b = AW'({root_q, 1'b1});
    end
  end

  assign alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

  assign sq_rem = rem_q[AW-1] ? alu_y[H:0] : rem_q[H:0];
  assign quo_s  = (sign_a_q ^ sign_b_q) ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
  assign rem_s  = sign_a_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        busy_d = start;
        if (start) begin
          op_d     = op;
          sign_a_d = data_a[W-1];
          sign_b_d = data_b[W-1];
          opnd_d   = (op == OpMul) ? mag_a : mag_b;
          acc_d    = (op == OpMul) ? {{W{1'b0}}, mag_b} : {{W{1'b0}}, mag_a};
          rem_d    = '0;
          root_d   = '0;
          cnt_d    = (op == OpSqrt) ? CW'(H) : CW'(W);
          err_d    = pre_err;
          state_d  = pre_err ? StFin : StCalc;
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 1'b1;
        unique case (op_q)
          OpMul: acc_d = {alu_y[W:0], acc_q[W-1:1]};
          OpDiv: begin
            rem_d = alu_y[AW-1] ? AW'(div_sh) : alu_y;
            acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~alu_y[AW-1]};
          end
          OpSqrt: begin
            rem_d  = alu_y;
            root_d = {root_q[H-2:0], ~alu_y[AW-1]};
            acc_d  = {acc_q[2*W-1:W], acc_q[W-3:0], 2'b00};
          end
          default: ;
        endcase
        if (cnt_q == CW'(1)) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
        error_d = err_q;
        if (err_q) begin
          result_d = '0;
        end else begin
          unique case (op_q)
            OpMul:  result_d = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
            OpDiv:  result_d = {rem_s, quo_s};
            OpSqrt: result_d = {{(W-H-1){1'b0}}, sq_rem, {(W-H){1'b0}}, root_q};
            default: result_d = '0;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed, table-driven bench for mdr_unit at WORD_LENGTH=16.
module tb_mdr_unit;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  data_a, data_b;
  logic          busy, done, error;
  logic [2*W-1:0] result;

  int checks = 0;
  int failures = 0;

  mdr_unit #(.WORD_LENGTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .data_a (data_a),
    .data_b (data_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request; returns #1 after the accept edge with start dropped.
  task automatic start_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o; data_a = a; data_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data_a = ~a;
    data_b = ~b;
  endtask

  // Counts edges until done is seen; -1 if the budget expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  int lat;

  initial begin
    vecs[0]  = '{"mul_neg3x7",    2'b00, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 1'b0, 17};
    vecs[1]  = '{"mul_min_min",   2'b00, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 17};
    vecs[2]  = '{"mul_max_min",   2'b00, 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0, 17};
    vecs[3]  = '{"mul_zero",      2'b00, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0, 17};
    vecs[4]  = '{"mul_pos",       2'b00, 16'h0123, 16'h0045, 32'h0000_4E6F, 1'b0, 17};
    vecs[5]  = '{"div_m100_7",    2'b01, 16'hFF9C, 16'h0007, 32'hFFFE_FFF2, 1'b0, 17};
    vecs[6]  = '{"div_100_m7",    2'b01, 16'h0064, 16'hFFF9, 32'h0002_FFF2, 1'b0, 17};
    vecs[7]  = '{"div_min_1",     2'b01, 16'h8000, 16'h0001, 32'h0000_8000, 1'b0, 17};
    vecs[8]  = '{"div_7_100",     2'b01, 16'h0007, 16'h0064, 32'h0007_0000, 1'b0, 17};
    vecs[9]  = '{"div_m7_7",      2'b01, 16'hFFF9, 16'h0007, 32'h0000_FFFF, 1'b0, 17};
    vecs[10] = '{"div_by_zero",   2'b01, 16'h1234, 16'h0000, 32'h0000_0000, 1'b1, 1};
    vecs[11] = '{"div_overflow",  2'b01, 16'h8000, 16'hFFFF, 32'h0000_0000, 1'b1, 1};
    vecs[12] = '{"sqrt_1000",     2'b10, 16'h03E8, 16'h0000, 32'h0027_001F, 1'b0, 9};
    vecs[13] = '{"sqrt_7fff",     2'b10, 16'h7FFF, 16'h0000, 32'h0006_00B5, 1'b0, 9};
    vecs[14] = '{"sqrt_2",        2'b10, 16'h0002, 16'h0000, 32'h0001_0001, 1'b0, 9};
    vecs[15] = '{"sqrt_0",        2'b10, 16'h0000, 16'h5555, 32'h0000_0000, 1'b0, 9};
    vecs[16] = '{"sqrt_neg",      2'b10, 16'hFFFF, 16'h0000, 32'h0000_0000, 1'b1, 1};
    vecs[17] = '{"op_reserved",   2'b11, 16'h0005, 16'h0003, 32'h0000_0000, 1'b1, 1};

    reset = 1'b0; start = 1'b0; op = '0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
      wait_done(lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_result"}, 64'(result), 64'(vecs[i].res));
      check({vecs[i].name, "_error"}, 64'(error), 64'(vecs[i].err));
      @(posedge clk);
      #1;
      check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
      check({vecs[i].name, "_busy_clear"}, 64'(busy), 64'd0);
      check({vecs[i].name, "_held"}, 64'(result), 64'(vecs[i].res));
    end

    // start during CALC is ignored
    start_op(2'b00, 16'hFFFD, 16'h0007);
    repeat (2) @(posedge clk);
    @(negedge clk);
    op = 2'b01; data_a = 16'h0064; data_b = 16'h0003; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check("ignore_latency", 64'(lat), 64'd14);
    check("ignore_result", 64'(result), 64'hFFFF_FFEB);

    // start in the done cycle is accepted; busy stays high
    check("b2b_busy_in_done", 64'(busy), 64'd1);
    start_op(2'b10, 16'h03E8, 16'h0000);
    check("b2b_busy_after", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd9);
    check("b2b_result", 64'(result), 64'h0027_001F);

    // asynchronous reset mid-operation
    start_op(2'b00, 16'h0123, 16'h0045);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_error", 64'(error), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    start_op(2'b01, 16'hFF9C, 16'h0007);
    wait_done(lat);
    check("post_reset_latency", 64'(lat), 64'd17);
    check("post_reset_result", 64'(result), 64'hFFFE_FFF2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
